// File: rtl/ysyx_bus_arb.sv
// rtl/ysyx_bus_arb.sv - IFU/LSU to single AXI4-Lite master arbiter (optional YSYX_BUS_RESP_CHECK_EN)
module ysyx_bus_arb #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    input  logic              ifu_required,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic [DATA_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [DATA_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [DATA_W-1:0] bus_araddr,
    output logic              bus_arvalid,
    input  logic              bus_arready,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic [1:0]        bus_rresp,
    input  logic              bus_rvalid,
    output logic              bus_rready,
    output logic [DATA_W-1:0] bus_awaddr,
    output logic              bus_awvalid,
    input  logic              bus_awready,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    output logic              bus_wvalid,
    input  logic              bus_wready,
    input  logic [1:0]        bus_bresp,
    input  logic              bus_bvalid,
    output logic              bus_bready,
    output logic              bus_err_o,
    output logic [DATA_W-1:0] bus_err_addr_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IF_AR = 3'd1,
        IF_R  = 3'd2,
        LS_AR = 3'd3,
        LS_R  = 3'd4,
        LS_W  = 3'd5,
        LS_B  = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done;
    logic              aw_ok, w_ok;

    assign ifu_rdata  = bus_rdata;
    assign lsu_rdata  = bus_rdata;
    assign bus_araddr = addr_q;
    assign bus_awaddr = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_wstrb  = wstrb_q;

    assign aw_ok = aw_done | (bus_awvalid & bus_awready);
    assign w_ok  = w_done | (bus_wvalid & bus_wready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                case (state_n)
                    IF_AR:   addr_q <= ifu_araddr;
                    LS_AR:   addr_q <= lsu_araddr;
                    LS_W: begin
                        addr_q  <= lsu_awaddr;
                        wdata_q <= lsu_wdata;
                        wstrb_q <= lsu_wstrb;
                    end
                    default: ;
                endcase
            end
            // AW and W may complete in different cycles; remember each one.
            if (state == LS_W) begin
                aw_done <= aw_ok;
                w_done  <= w_ok;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n     = IDLE;
        bus_arvalid = 1'b0;
        bus_rready  = 1'b0;
        bus_awvalid = 1'b0;
        bus_wvalid  = 1'b0;
        bus_bready  = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_wready  = 1'b0;
        case (state)
            IDLE: begin
                // A refill in progress locks the bus to the IFU.
                if (ifu_required) begin
                    if (ifu_arvalid) state_n = IF_AR;
                end else if (lsu_arvalid) begin
                    state_n = LS_AR;
                end else if (lsu_awvalid && lsu_wvalid) begin
                    state_n = LS_W;
                end else if (ifu_arvalid) begin
                    state_n = IF_AR;
                end
            end
            IF_AR: begin
                bus_arvalid = 1'b1;
                state_n     = bus_arready ? IF_R : IF_AR;
            end
            IF_R: begin
                bus_rready = 1'b1;
                ifu_rvalid = bus_rvalid;
                state_n    = bus_rvalid ? IDLE : IF_R;
            end
            LS_AR: begin
                bus_arvalid = 1'b1;
                state_n     = bus_arready ? LS_R : LS_AR;
            end
            LS_R: begin
                bus_rready = 1'b1;
                lsu_rvalid = bus_rvalid;
                state_n    = bus_rvalid ? IDLE : LS_R;
            end
            LS_W: begin
                bus_awvalid = ~aw_done;
                bus_wvalid  = ~w_done;
                state_n     = (aw_ok && w_ok) ? LS_B : LS_W;
            end
            LS_B: begin
                bus_bready = 1'b1;
                lsu_wready = bus_bvalid;
                state_n    = bus_bvalid ? IDLE : LS_B;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef YSYX_BUS_RESP_CHECK_EN
    logic              err_q;
    logic [DATA_W-1:0] err_addr_q;
    logic              resp_err;

    assign resp_err = (bus_rvalid & bus_rready & (|bus_rresp))
                    | (bus_bvalid & bus_bready & (|bus_bresp));

    // Only the first faulting address is kept; the flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (resp_err) begin
            err_q <= 1'b1;
            if (!err_q) err_addr_q <= addr_q;
        end
    end

    assign bus_err_o      = err_q;
    assign bus_err_addr_o = err_addr_q;
`else
    logic unused_resp;
    assign unused_resp    = ^{bus_rresp, bus_bresp};
    assign bus_err_o      = 1'b0;
    assign bus_err_addr_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// tb/tb_ysyx_bus_arb.sv - directed self-checking bench for ysyx_bus_arb
module tb_ysyx_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic        ifu_arvalid, ifu_required, ifu_rvalid;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic        lsu_arvalid, lsu_rvalid;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic        lsu_awvalid, lsu_wvalid, lsu_wready;
    logic [3:0]  lsu_wstrb;
    logic [31:0] bus_araddr, bus_rdata, bus_awaddr, bus_wdata, bus_err_addr_o;
    logic        bus_arvalid, bus_arready, bus_rvalid, bus_rready;
    logic        bus_awvalid, bus_awready, bus_wvalid, bus_wready;
    logic        bus_bvalid, bus_bready, bus_err_o;
    logic [1:0]  bus_rresp, bus_bresp;
    logic [3:0]  bus_wstrb;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_bus_arb #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_required(ifu_required),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_bresp(bus_bresp), .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
        .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o)
    );

    // Inputs change just after a falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 0; ifu_required = 0;
        lsu_araddr = '0; lsu_arvalid = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
        bus_arready = 0; bus_rdata = '0; bus_rresp = '0; bus_rvalid = 0;
        bus_awready = 0; bus_wready = 0; bus_bresp = '0; bus_bvalid = 0;
        step(); step(); #1;
        n_cmp++;
        if ({bus_arvalid, bus_rready, bus_awvalid, bus_wvalid, bus_bready,
             ifu_rvalid, lsu_rvalid, lsu_wready, bus_err_o} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 0", {bus_arvalid, bus_rready, bus_awvalid,
                     bus_wvalid, bus_bready, ifu_rvalid, lsu_rvalid, lsu_wready, bus_err_o});
        end
        n_cmp++;
        if (bus_err_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_err_addr: got %h expected 0", bus_err_addr_o);
        end
        step(); rst = 1'b0;
    endtask

    task automatic test_ifu_read();
        ifu_araddr = 32'h3000_0000; ifu_arvalid = 1; #1;
        n_cmp++;
        if (bus_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL ifu_c0_arvalid: got %b expected 0", bus_arvalid);
        end
        step(); bus_arready = 1; #1;
        n_cmp++;
        if (bus_arvalid !== 1'b1 || bus_araddr !== 32'h3000_0000) begin
            n_fail++; $display("FAIL ifu_c1_ar: got %b/%h expected 1/30000000", bus_arvalid, bus_araddr);
        end
        step(); bus_arready = 0; bus_rvalid = 1; bus_rdata = 32'h0000_0413; #1;
        n_cmp++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || lsu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_c2_resp: got rv=%b rd=%h lrv=%b expected 1/00000413/0", ifu_rvalid, ifu_rdata, lsu_rvalid);
        end
        step(); ifu_arvalid = 0; bus_rvalid = 0; #1;
        n_cmp++;
        if (ifu_rvalid !== 1'b0 || bus_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL ifu_c3_idle: got rv=%b arv=%b expected 0/0", ifu_rvalid, bus_arvalid);
        end
    endtask

    task automatic test_priority();
        ifu_araddr = 32'h3000_0040; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_0100; lsu_arvalid = 1;
        step(); bus_arready = 1; #1;
        n_cmp++;
        if (bus_arvalid !== 1'b1 || bus_araddr !== 32'h8000_0100) begin
            n_fail++; $display("FAIL prio_first_ar: got %b/%h expected 1/80000100", bus_arvalid, bus_araddr);
        end
        step(); bus_arready = 0; bus_rvalid = 1; bus_rdata = 32'h1234_5678; #1;
        n_cmp++;
        if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0 || lsu_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL prio_lsu_resp: got lrv=%b irv=%b rd=%h expected 1/0/12345678",
                               lsu_rvalid, ifu_rvalid, lsu_rdata);
        end
        step(); lsu_arvalid = 0; bus_rvalid = 0; #1;
        n_cmp++;
        if (bus_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL prio_idle_gap: got %b expected 0", bus_arvalid);
        end
        step(); bus_arready = 1; #1;
        n_cmp++;
        if (bus_arvalid !== 1'b1 || bus_araddr !== 32'h3000_0040) begin
            n_fail++; $display("FAIL prio_second_ar: got %b/%h expected 1/30000040", bus_arvalid, bus_araddr);
        end
        step(); bus_arready = 0; bus_rvalid = 1; #1;
        n_cmp++;
        if (ifu_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL prio_ifu_resp: got %b expected 1", ifu_rvalid);
        end
        step(); ifu_arvalid = 0; bus_rvalid = 0;
    endtask

    task automatic test_refill_lock();
        ifu_required = 1; ifu_araddr = 32'h3000_0008; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_0000; lsu_arvalid = 1;
        step(); bus_arready = 1; #1;
        n_cmp++;
        if (bus_araddr !== 32'h3000_0008 || bus_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat1_ar: got %b/%h expected 1/30000008", bus_arvalid, bus_araddr);
        end
        step(); bus_arready = 0; bus_rvalid = 1; bus_rdata = 32'h1111_0001; #1;
        n_cmp++;
        if (ifu_rvalid !== 1'b1 || lsu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL lock_beat1_resp: got %b/%b expected 1/0", ifu_rvalid, lsu_rvalid);
        end
        step(); bus_rvalid = 0; ifu_araddr = 32'h3000_000C;
        step(); bus_arready = 1; #1;
        n_cmp++;
        if (bus_araddr !== 32'h3000_000C || bus_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat2_ar: got %b/%h expected 1/3000000c", bus_arvalid, bus_araddr);
        end
        step(); bus_arready = 0; bus_rvalid = 1; bus_rdata = 32'h2222_0002; #1;
        n_cmp++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h2222_0002) begin
            n_fail++; $display("FAIL lock_beat2_resp: got %b/%h expected 1/22220002", ifu_rvalid, ifu_rdata);
        end
        step(); bus_rvalid = 0; ifu_arvalid = 0; ifu_required = 0;
        step(); bus_arready = 1; #1;
        n_cmp++;
        if (bus_araddr !== 32'h8000_0000 || bus_arvalid !== 1'b1) begin
            n_fail++; $display("FAIL lock_lsu_after: got %b/%h expected 1/80000000", bus_arvalid, bus_araddr);
        end
        step(); bus_arready = 0; bus_rvalid = 1; #1;
        n_cmp++;
        if (lsu_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL lock_lsu_resp: got %b expected 1", lsu_rvalid);
        end
        step(); lsu_arvalid = 0; bus_rvalid = 0;
    endtask

    task automatic test_write();
        lsu_awaddr = 32'h0f00_0010; lsu_wdata = 32'hdead_beef; lsu_wstrb = 4'h3;
        lsu_awvalid = 1; lsu_wvalid = 1; #1;
        n_cmp++;
        if (bus_awvalid !== 1'b0 || bus_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_c0: got %b/%b expected 0/0", bus_awvalid, bus_wvalid);
        end
        step(); bus_wready = 1; bus_awready = 0; #1;
        n_cmp++;
        if (bus_awvalid !== 1'b1 || bus_wvalid !== 1'b1 || bus_awaddr !== 32'h0f00_0010 ||
            bus_wdata !== 32'hdead_beef || bus_wstrb !== 4'h3) begin
            n_fail++; $display("FAIL wr_c1: got %b/%b %h %h %h expected 1/1 0f000010 deadbeef 3",
                               bus_awvalid, bus_wvalid, bus_awaddr, bus_wdata, bus_wstrb);
        end
        step(); bus_wready = 0; #1;
        n_cmp++;
        if (bus_wvalid !== 1'b0 || bus_awvalid !== 1'b1) begin
            n_fail++; $display("FAIL wr_c2: got w=%b aw=%b expected 0/1", bus_wvalid, bus_awvalid);
        end
        step(); bus_awready = 1; #1;
        n_cmp++;
        if (bus_awvalid !== 1'b1 || bus_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_c3: got aw=%b w=%b expected 1/0", bus_awvalid, bus_wvalid);
        end
        step(); bus_awready = 0; #1;
        n_cmp++;
        if (bus_awvalid !== 1'b0 || bus_bready !== 1'b1 || lsu_wready !== 1'b0) begin
            n_fail++; $display("FAIL wr_c4: got aw=%b br=%b wr=%b expected 0/1/0", bus_awvalid, bus_bready, lsu_wready);
        end
        step(); bus_bvalid = 1; #1;
        n_cmp++;
        if (lsu_wready !== 1'b1) begin
            n_fail++; $display("FAIL wr_bresp: got %b expected 1", lsu_wready);
        end
        step(); bus_bvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0; #1;
        n_cmp++;
        if (lsu_wready !== 1'b0 || bus_bready !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got wr=%b br=%b expected 0/0", lsu_wready, bus_bready);
        end
    endtask

    task automatic test_mid_reset();
        ifu_araddr = 32'h3000_0020; ifu_arvalid = 1;
        step(); bus_arready = 1;
        step(); bus_arready = 0; #1;
        n_cmp++;
        if (bus_rready !== 1'b1) begin
            n_fail++; $display("FAIL mrst_in_ifr: got %b expected 1", bus_rready);
        end
        step(); rst = 1; ifu_arvalid = 0;
        step(); rst = 0; bus_rvalid = 1; bus_rdata = 32'hbad0_0000; #1;
        n_cmp++;
        if (ifu_rvalid !== 1'b0 || bus_rready !== 1'b0 || bus_arvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL mrst_late_rvalid: got irv=%b rr=%b arv=%b lrv=%b expected 0/0/0/0",
                               ifu_rvalid, bus_rready, bus_arvalid, lsu_rvalid);
        end
        step(); bus_rvalid = 0;
    endtask

    task automatic test_resp_err();
        logic        exp_err;
        logic [31:0] exp_addr;
`ifdef YSYX_BUS_RESP_CHECK_EN
        exp_err = 1'b1; exp_addr = 32'h1000_0004;
`else
        exp_err = 1'b0; exp_addr = 32'h0;
`endif
        lsu_araddr = 32'h1000_0004; lsu_arvalid = 1;
        step(); bus_arready = 1;
        step(); bus_arready = 0; bus_rvalid = 1; bus_rresp = 2'd2; bus_rdata = 32'h5555_aaaa; #1;
        n_cmp++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h5555_aaaa) begin
            n_fail++; $display("FAIL err_data_fwd: got %b/%h expected 1/5555aaaa", lsu_rvalid, lsu_rdata);
        end
        step(); bus_rvalid = 0; bus_rresp = 0; lsu_arvalid = 0; #1;
        n_cmp++;
        if (bus_err_o !== exp_err || bus_err_addr_o !== exp_addr) begin
            n_fail++; $display("FAIL err_first: got %b/%h expected %b/%h", bus_err_o, bus_err_addr_o, exp_err, exp_addr);
        end
        lsu_araddr = 32'h1000_0008; lsu_arvalid = 1;
        step(); bus_arready = 1;
        step(); bus_arready = 0; bus_rvalid = 1; bus_rresp = 2'd1;
        step(); bus_rvalid = 0; bus_rresp = 0; lsu_arvalid = 0; #1;
        n_cmp++;
        if (bus_err_o !== exp_err || bus_err_addr_o !== exp_addr) begin
            n_fail++; $display("FAIL err_sticky: got %b/%h expected %b/%h", bus_err_o, bus_err_addr_o, exp_err, exp_addr);
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_priority();
        test_refill_lock();
        test_write();
        test_mid_reset();
        test_resp_err();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_bus_arb.md
# ysyx_bus_arb

Shared-bus arbiter that sits directly upstream of the instruction fetch unit and the load/store unit. It merges IFU instruction-line reads and LSU data reads/writes onto one AXI4-Lite master port toward the SoC interconnect. It holds at most one outstanding transaction at any time. It keeps the bus locked to the IFU for the full two-beat L1I line refill.

## Interface
- `DATA_W`, 32, address and data width.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ifu_araddr` in DATA_W, `ifu_arvalid` in 1: IFU read request, level-held until `ifu_rvalid`.
- `ifu_required` in 1: IFU refill in progress; locks ownership to the IFU.
- `ifu_rdata` out DATA_W, `ifu_rvalid` out 1: one-cycle response pulse.
- `lsu_araddr` in DATA_W, `lsu_arvalid` in 1: LSU read request, level-held until `lsu_rvalid`.
- `lsu_rdata` out DATA_W, `lsu_rvalid` out 1: one-cycle response pulse.
- `lsu_awaddr` in DATA_W, `lsu_awvalid` in 1, `lsu_wdata` in DATA_W, `lsu_wstrb` in 4, `lsu_wvalid` in 1: LSU write request, level-held until `lsu_wready`.
- `lsu_wready` out 1: one-cycle write-complete pulse.
- `bus_araddr` out DATA_W, `bus_arvalid` out 1, `bus_arready` in 1: AR channel.
- `bus_rdata` in DATA_W, `bus_rresp` in 2, `bus_rvalid` in 1, `bus_rready` out 1: R channel.
- `bus_awaddr` out DATA_W, `bus_awvalid` out 1, `bus_awready` in 1: AW channel.
- `bus_wdata` out DATA_W, `bus_wstrb` out 4, `bus_wvalid` out 1, `bus_wready` in 1: W channel.
- `bus_bresp` in 2, `bus_bvalid` in 1, `bus_bready` out 1: B channel.
- `bus_err_o` out 1, `bus_err_addr_o` out DATA_W: sticky error flag and address of the first faulting transaction (see Configuration).

## Operation
- States: IDLE, IF_AR, IF_R, LS_AR, LS_R, LS_W, LS_B.
- Arbitration in IDLE, evaluated in this order:
  - If `ifu_required` is high: only the IFU may be granted (lock). An `ifu_arvalid` goes to IF_AR. Any LSU request waits.
  - Else `lsu_arvalid` goes to LS_AR.
  - Else `lsu_awvalid & lsu_wvalid` goes to LS_W.
  - Else `ifu_arvalid` goes to IF_AR.
  - LSU has priority over the IFU when unlocked. An LSU read has priority over an LSU write.
- On grant, the address, write data and strobe are latched into internal registers. Master outputs are driven from these registers only, never from requester inputs.
- IF_AR / LS_AR: `bus_arvalid`=1 until `bus_arready`, then go to the matching R state.
- IF_R / LS_R: `bus_rready`=1. On `bus_rvalid`:
  - `bus_rdata` is forwarded combinationally to the owner's rdata.
  - The owner's rvalid pulses in that same cycle.
  - State returns to IDLE.
- The non-owner's rvalid is always 0. Both `ifu_rdata` and `lsu_rdata` are driven with `bus_rdata` at all times.
- LS_W: `bus_awvalid` and `bus_wvalid` start high together. Each drops independently after its own handshake. Once both handshakes are done, go to LS_B.
- LS_B: `bus_bready`=1. On `bus_bvalid`, pulse `lsu_wready` for one cycle and return to IDLE.
- Only single-beat transfers are issued. The IFU burst fetch mode is unsupported; `YSYX_I_SDRAM_ARBURST` must be 0.
- Any undefined state encoding goes to IDLE.

## Timing
- Reset values: state IDLE. All `bus_*valid`, `bus_rready`, `bus_bready`, `ifu_rvalid`, `lsu_rvalid`, `lsu_wready` and `bus_err_o` are 0. `bus_err_addr_o` is 0.
- Minimum read latency, zero-wait slave:
  - cycle 0: request seen in IDLE;
  - cycle 1: `bus_arvalid` high, `bus_arready` high;
  - cycle 2: `bus_rvalid` high, requester rvalid pulses.
- Minimum write latency: request at cycle 0, AW/W handshake at cycle 1, B response and `lsu_wready` at cycle 2.
- Back-to-back: IDLE is always visited for exactly one cycle between transactions.
- A requester whose valid drops while waiting in IDLE is simply not granted. Once granted, the transaction runs to completion regardless of requester inputs.
- A mid-operation `rst` returns the block to IDLE on the next edge and drops all valids. The in-flight transaction is abandoned, and no response pulse is generated.
- `ifu_required` rising while the LSU owns the bus does not preempt the LSU. The lock takes effect at the next IDLE.

## Configuration
- `YSYX_BUS_RESP_CHECK_EN` defined:
  - Any completed R or B beat with a nonzero resp sets `bus_err_o`.
  - If `bus_err_o` was 0, the latched transaction address is also captured into `bus_err_addr_o`.
  - Both are sticky until `rst`.
  - Data is still forwarded and the response pulse still occurs.
- Not defined: `bus_err_o` and `bus_err_addr_o` are tied to 0, resp inputs are ignored, and the error registers are not synthesized.

## Test plan
- IFU read 0x3000_0000, zero-wait slave returns 0x0000_0413 -> `ifu_rvalid` for exactly 1 cycle at cycle 2, `ifu_rdata`=0x0000_0413, `lsu_rvalid`=0.
- `ifu_arvalid` and `lsu_arvalid` rise together with `ifu_required`=0 -> the LSU address appears first on `bus_araddr`, and the IFU is served in the next transaction.
- IFU two-beat refill at 0x3000_0008 / 0x3000_000C with `ifu_required` held high; LSU read 0x8000_0000 pending -> both IFU beats complete before the LSU AR appears.
- LSU write 0x0f00_0010, wdata 0xdead_beef, wstrb 0x3; `bus_awready` delayed 3 cycles, `bus_wready` immediate -> `bus_wvalid` drops after 1 cycle, `bus_awvalid` after 3, then a single `lsu_wready` pulse after `bus_bvalid`.
- `rst` asserted in IF_R before `bus_rvalid` -> next cycle IDLE with all valids 0, and a late `bus_rvalid` produces no `ifu_rvalid`.
- With `YSYX_BUS_RESP_CHECK_EN`, LSU read 0x1000_0004 returns rresp=2 -> `bus_err_o`=1 and `bus_err_addr_o`=0x1000_0004. A later error leaves the address unchanged.
